// File: rtl/e_xalu.sv
// E-stage ALU with a multi-cycle MULT/DIV unit and HI/LO registers.
// Single-cycle ops are combinational; mult/div results are written to HI/LO once the busy count expires.
module e_xalu #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       op,
  input  logic             ov_en,
  input  logic             start,
  input  logic             flush,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       exc_code,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_OR    = 5'd2;
  localparam logic [4:0] OP_AND   = 5'd3;
  localparam logic [4:0] OP_SLT   = 5'd4;
  localparam logic [4:0] OP_SLTU  = 5'd5;
  localparam logic [4:0] OP_LUI   = 5'd6;
  localparam logic [4:0] OP_MULT  = 5'd7;
  localparam logic [4:0] OP_MULTU = 5'd8;
  localparam logic [4:0] OP_DIV   = 5'd9;
  localparam logic [4:0] OP_DIVU  = 5'd10;
  localparam logic [4:0] OP_MFHI  = 5'd11;
  localparam logic [4:0] OP_MFLO  = 5'd12;
  localparam logic [4:0] OP_MTHI  = 5'd13;
  localparam logic [4:0] OP_MTLO  = 5'd14;

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] hi_n, lo_n;
  logic [4:0]       op_q, op_n;
  logic [WIDTH-1:0] a_q, a_n, b_q, b_n;

  // One extra sign bit exposes signed overflow as bit[WIDTH] != bit[WIDTH-1].
  logic [WIDTH:0] add_x, sub_x;
  assign add_x = {A[WIDTH-1], A} + {B[WIDTH-1], B};
  assign sub_x = {A[WIDTH-1], A} - {B[WIDTH-1], B};

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = add_x[WIDTH-1:0];
      OP_SUB:  result = sub_x[WIDTH-1:0];
      OP_OR:   result = A | B;
      OP_AND:  result = A & B;
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: result = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_LUI:  result = B << (WIDTH/2);
      OP_MFHI: result = hi;
      OP_MFLO: result = lo;
      default: result = '0;
    endcase
  end

  always_comb begin
    exc_code = 5'd0;
    if (ov_en && (((op == OP_ADD) && (add_x[WIDTH] ^ add_x[WIDTH-1])) ||
                  ((op == OP_SUB) && (sub_x[WIDTH] ^ sub_x[WIDTH-1]))))
      exc_code = 5'd12;
  end

  // Mult/div datapath works only from the operands captured at accept.
  logic                 sgn_q, is_mul_q, div_zero;
  logic [2*WIDTH-1:0]   ext_a, ext_b, prod;
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     mag_a, mag_b, divisor, uq, ur, quot, rem;

  assign sgn_q    = (op_q == OP_MULT) || (op_q == OP_DIV);
  assign is_mul_q = (op_q == OP_MULT) || (op_q == OP_MULTU);
  assign ext_a    = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
  assign ext_b    = sgn_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
  assign prod     = ext_a * ext_b;

  // Most-negative / -1 falls out naturally: its magnitude negates back to itself.
  assign a_neg    = sgn_q & a_q[WIDTH-1];
  assign b_neg    = sgn_q & b_q[WIDTH-1];
  assign mag_a    = a_neg ? -a_q : a_q;
  assign mag_b    = b_neg ? -b_q : b_q;
  assign div_zero = (b_q == '0);
  assign divisor  = div_zero ? WIDTH'(1) : mag_b;
  assign uq       = mag_a / divisor;
  assign ur       = mag_a % divisor;
  assign quot     = (a_neg ^ b_neg) ? -uq : uq;
  assign rem      = a_neg ? -ur : ur;

  logic issue, is_md;
  assign issue = start & ~flush;
  assign is_md = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  assign busy  = (state == RUN);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hi_n    = hi;
    lo_n    = lo;
    op_n    = op_q;
    a_n     = a_q;
    b_n     = b_q;
    case (state)
      IDLE: begin
        if (issue && is_md) begin
          state_n = RUN;
          op_n    = op;
          a_n     = A;
          b_n     = B;
          cnt_n   = ((op == OP_MULT) || (op == OP_MULTU)) ? CW'(MUL_CYCLES) : CW'(DIV_CYCLES);
        end else if (issue && (op == OP_MTHI)) begin
          hi_n = A;
        end else if (issue && (op == OP_MTLO)) begin
          lo_n = A;
        end
      end
      RUN: begin
        if (cnt == CW'(1)) begin
          state_n = IDLE;
          cnt_n   = '0;
          if (is_mul_q) begin
            hi_n = prod[2*WIDTH-1:WIDTH];
            lo_n = prod[WIDTH-1:0];
          end else if (!div_zero) begin
            hi_n = rem;
            lo_n = quot;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      hi    <= hi_n;
      lo    <= lo_n;
      op_q  <= op_n;
      a_q   <= a_n;
      b_q   <= b_n;
    end
  end

endmodule

// File: tb/tb_e_xalu.sv
// Directed self-checking bench for e_xalu: a default 32-bit instance plus a
// 16-bit instance with short mult/div latencies.
module tb_e_xalu;

  logic clk;
  logic reset;

  logic [31:0] a32, b32, result32, hi32, lo32;
  logic [4:0]  op32, exc32;
  logic        ov_en32, start32, flush32, busy32;

  logic [15:0] a16, b16, result16, hi16, lo16;
  logic [4:0]  op16, exc16;
  logic        ov_en16, start16, flush16, busy16;

  int errors = 0;
  int checks = 0;

  e_xalu dut32 (
    .clk(clk), .reset(reset), .A(a32), .B(b32), .op(op32), .ov_en(ov_en32),
    .start(start32), .flush(flush32), .result(result32), .exc_code(exc32),
    .busy(busy32), .hi(hi32), .lo(lo32)
  );

  e_xalu #(.WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(3)) dut16 (
    .clk(clk), .reset(reset), .A(a16), .B(b16), .op(op16), .ov_en(ov_en16),
    .start(start16), .flush(flush16), .result(result16), .exc_code(exc16),
    .busy(busy16), .hi(hi16), .lo(lo16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                               input logic ov, input logic st, input logic fl);
    op32    = o;
    a32     = a;
    b32     = b;
    ov_en32 = ov;
    start32 = st;
    flush32 = fl;
    #1;
  endtask

  // Issues a mult/div for one cycle, scrambles the operand inputs, then counts busy cycles.
  task automatic runMulDiv(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                           input int cycles, input string tag);
    int n;
    applyStimulus(o, a, b, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(5'd31, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (busy32 && n < 100) begin
      n++;
      tick();
    end
    checkOutput({tag, "_busy_cycles"}, 64'(n), 64'(cycles));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset = 1'b1;
    a16 = '0; b16 = '0; op16 = 5'd31; ov_en16 = 1'b0; start16 = 1'b0; flush16 = 1'b0;
    applyStimulus(5'd31, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("reset_busy", 64'(busy32), 64'd0);
    checkOutput("reset_hi", 64'(hi32), 64'd0);
    checkOutput("reset_lo", 64'(lo32), 64'd0);
    checkOutput("reset_busy16", 64'(busy16), 64'd0);
    reset = 1'b0;
    tick();

    // Single-cycle operations
    applyStimulus(5'd0, 32'h7FFFFFFF, 32'h1, 1'b1, 1'b0, 1'b0);
    checkOutput("add_ov_result", 64'(result32), 64'h80000000);
    checkOutput("add_ov_exc", 64'(exc32), 64'd12);
    applyStimulus(5'd0, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 1'b0);
    checkOutput("addu_exc", 64'(exc32), 64'd0);
    applyStimulus(5'd1, 32'h80000000, 32'h1, 1'b1, 1'b0, 1'b0);
    checkOutput("sub_ov_exc", 64'(exc32), 64'd12);
    checkOutput("sub_ov_result", 64'(result32), 64'h7FFFFFFF);
    applyStimulus(5'd0, 32'h00000005, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0);
    checkOutput("add_noov_result", 64'(result32), 64'h3);
    checkOutput("add_noov_exc", 64'(exc32), 64'd0);
    applyStimulus(5'd2, 32'hF0F0_0000, 32'h0000_0F0F, 1'b0, 1'b0, 1'b0);
    checkOutput("or", 64'(result32), 64'hF0F00F0F);
    applyStimulus(5'd3, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0);
    checkOutput("and", 64'(result32), 64'h0F000F00);
    applyStimulus(5'd4, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 1'b0);
    checkOutput("slt", 64'(result32), 64'd1);
    applyStimulus(5'd5, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 1'b0);
    checkOutput("sltu", 64'(result32), 64'd0);
    applyStimulus(5'd6, 32'h0, 32'h0000ABCD, 1'b0, 1'b0, 1'b0);
    checkOutput("lui", 64'(result32), 64'hABCD0000);
    applyStimulus(5'd7, 32'h12345678, 32'h9, 1'b1, 1'b0, 1'b0);
    checkOutput("mult_result_zero", 64'(result32), 64'd0);

    // Multiply and divide
    runMulDiv(5'd7, 32'hFFFFFFFE, 32'h3, 5, "mult");
    checkOutput("mult_hi", 64'(hi32), 64'hFFFFFFFF);
    checkOutput("mult_lo", 64'(lo32), 64'hFFFFFFFA);
    runMulDiv(5'd8, 32'hFFFFFFFE, 32'h3, 5, "multu");
    checkOutput("multu_hi", 64'(hi32), 64'h2);
    checkOutput("multu_lo", 64'(lo32), 64'hFFFFFFFA);
    runMulDiv(5'd9, 32'hFFFFFFF9, 32'h2, 10, "div");
    checkOutput("div_lo", 64'(lo32), 64'hFFFFFFFD);
    checkOutput("div_hi", 64'(hi32), 64'hFFFFFFFF);
    runMulDiv(5'd9, 32'h80000000, 32'hFFFFFFFF, 10, "div_minneg");
    checkOutput("div_minneg_lo", 64'(lo32), 64'h80000000);
    checkOutput("div_minneg_hi", 64'(hi32), 64'h0);
    runMulDiv(5'd10, 32'h12345678, 32'h0, 10, "divu_zero");
    checkOutput("divu_zero_hi", 64'(hi32), 64'h0);
    checkOutput("divu_zero_lo", 64'(lo32), 64'h80000000);
    runMulDiv(5'd10, 32'hFFFFFFF9, 32'h2, 10, "divu");
    checkOutput("divu_lo", 64'(lo32), 64'h7FFFFFFC);
    checkOutput("divu_hi", 64'(hi32), 64'h1);

    // Flush on the start cycle suppresses the accept
    applyStimulus(5'd7, 32'h5, 32'h6, 1'b0, 1'b1, 1'b1);
    tick();
    checkOutput("flush_start_busy", 64'(busy32), 64'd0);
    applyStimulus(5'd31, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("flush_start_hi", 64'(hi32), 64'h1);
    checkOutput("flush_start_lo", 64'(lo32), 64'h7FFFFFFC);

    // Flush during RUN does not abort; MTLO while busy is ignored
    applyStimulus(5'd7, 32'h5, 32'h6, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(5'd31, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(5'd14, 32'h1234, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(5'd31, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (busy32 && n < 100) begin
      n++;
      tick();
    end
    checkOutput("flush_run_remaining", 64'(n), 64'd3);
    checkOutput("flush_run_hi", 64'(hi32), 64'h0);
    checkOutput("flush_run_lo", 64'(lo32), 64'h1E);

    // MTHI/MTLO when idle, then MFHI/MFLO
    applyStimulus(5'd13, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(5'd14, 32'h55, 32'h0, 1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(5'd11, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("mthi_mfhi", 64'(result32), 64'hDEADBEEF);
    applyStimulus(5'd12, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("mtlo_flushed_mflo", 64'(result32), 64'h1E);

    // Reset in the middle of a divide
    applyStimulus(5'd9, 32'd100, 32'd7, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(5'd31, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("mid_div_busy", 64'(busy32), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("reset_div_busy", 64'(busy32), 64'd0);
    checkOutput("reset_div_hi", 64'(hi32), 64'h0);
    checkOutput("reset_div_lo", 64'(lo32), 64'h0);
    repeat (15) tick();
    checkOutput("reset_div_late_hi", 64'(hi32), 64'h0);
    checkOutput("reset_div_late_lo", 64'(lo32), 64'h0);

    // 16-bit instance with short latencies
    op16 = 5'd6; b16 = 16'h00AB;
    #1;
    checkOutput("w16_lui", 64'(result16), 64'hAB00);
    op16 = 5'd7; a16 = 16'hFFFE; b16 = 16'h0003; start16 = 1'b1;
    tick();
    start16 = 1'b0; op16 = 5'd31; a16 = 16'h1111; b16 = 16'h2222;
    n = 0;
    while (busy16 && n < 100) begin
      n++;
      tick();
    end
    checkOutput("w16_mult_busy_cycles", 64'(n), 64'd1);
    checkOutput("w16_mult_hi", 64'(hi16), 64'hFFFF);
    checkOutput("w16_mult_lo", 64'(lo16), 64'hFFFA);
    op16 = 5'd9; a16 = 16'd7; b16 = 16'd2; start16 = 1'b1;
    tick();
    start16 = 1'b0; op16 = 5'd31;
    n = 0;
    while (busy16 && n < 100) begin
      n++;
      tick();
    end
    checkOutput("w16_div_busy_cycles", 64'(n), 64'd3);
    checkOutput("w16_div_lo", 64'(lo16), 64'h3);
    checkOutput("w16_div_hi", 64'(hi16), 64'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/e_xalu.md
E_XALU -- requirements
Module: e_xalu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width (even, >=8).
REQ-002 SHALL have parameter MUL_CYCLES, default 5, busy cycles for MULT/MULTU (>=1).
REQ-003 SHALL have parameter DIV_CYCLES, default 10, busy cycles for DIV/DIVU (>=1).
REQ-004 clk  in  1  rising-edge clock; sole clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 A  in  WIDTH  operand A (rs).
REQ-007 B  in  WIDTH  operand B (rt or extended immediate).
REQ-008 op  in  5  operation: 0 ADD, 1 SUB, 2 OR, 3 AND, 4 SLT, 5 SLTU, 6 LUI, 7 MULT, 8 MULTU, 9 DIV, 10 DIVU, 11 MFHI, 12 MFLO, 13 MTHI, 14 MTLO; other codes are NOP.
REQ-009 ov_en  in  1  1 = ADD/SUB trap on signed overflow (add/sub); 0 = addu/subu.
REQ-010 start  in  1  instruction valid in E stage this cycle.
REQ-011 flush  in  1  exception/interrupt commit this cycle; suppresses all state changes requested this cycle.
REQ-012 result  out  WIDTH  combinational result.
REQ-013 exc_code  out  5  combinational: 0 = none, 12 = Ov.
REQ-014 busy  out  1  registered; mult/div in progress.
REQ-015 hi  out  WIDTH  registered HI.
REQ-016 lo  out  WIDTH  registered LO.

Function
REQ-017 ADD/SUB SHALL compute A+B / A-B modulo 2^WIDTH; overflow = sign-extended (WIDTH+1)-bit result bits [WIDTH] and [WIDTH-1] differ.
REQ-018 exc_code SHALL be 12 iff op in {ADD,SUB}, ov_en=1, and overflow; otherwise 0; independent of start/busy.
REQ-019 OR/AND bitwise; SLT signed compare, SLTU unsigned, result 1 or 0 zero-extended; LUI = B << (WIDTH/2).
REQ-020 MFHI/MFLO SHALL drive result = hi / lo; MULT..MTLO and NOP drive result = 0.
REQ-021 State machine SHALL have two states: IDLE (busy=0) and RUN (busy=1) with a down-counter sized for max(MUL_CYCLES,DIV_CYCLES).
REQ-022 Accept = start & !flush & !busy & op in {MULT,MULTU,DIV,DIVU}; on accept edge: latch operands and op, load counter with MUL_CYCLES or DIV_CYCLES, enter RUN.
REQ-023 In RUN each edge SHALL decrement counter; on the edge where counter==1, write HI/LO and return to IDLE; busy is high for exactly N cycles after the accept edge.
REQ-024 MULT: {hi,lo} = signed 2*WIDTH product; MULTU unsigned product.
REQ-025 DIV: lo = quotient truncated toward zero, hi = remainder with sign of dividend; DIVU unsigned.
REQ-026 DIV with A = most-negative, B = -1: lo = most-negative, hi = 0.
REQ-027 Divide by zero (DIV/DIVU): run full DIV_CYCLES, hi and lo unchanged.
REQ-028 MTHI/MTLO with start & !flush & !busy SHALL write hi / lo from A on that edge.
REQ-029 Any mult/div/MT op with busy=1 SHALL be ignored (upstream stalls); start with flush=1 SHALL change no state.
REQ-030 flush during RUN SHALL NOT abort; in-flight op completes and writes HI/LO.
REQ-031 Operands SHALL be taken only from latched copies during RUN; A/B changes after accept have no effect.

Reset
REQ-032 reset=1 at an edge SHALL force IDLE, counter 0, busy 0, hi 0, lo 0, aborting any in-flight op with no HI/LO write; reset dominates start and flush.
REQ-033 result and exc_code have no reset value (combinational from inputs and hi/lo).

Verification
REQ-034 WIDTH=32, ADD A=7FFFFFFF B=1 ov_en=1 -> result 80000000, exc_code 12; same with ov_en=0 -> exc_code 0; SUB 80000000-1 ov_en=1 -> exc_code 12.
REQ-035 MULT A=FFFFFFFE(-2) B=3, start one cycle -> busy high exactly 5 cycles, then hi FFFFFFFF, lo FFFFFFFA; MULTU same operands -> hi 2, lo FFFFFFFA.
REQ-036 DIV A=FFFFFFF9(-7) B=2 -> after 10 busy cycles lo FFFFFFFD, hi FFFFFFFF; DIV 80000000/FFFFFFFF -> lo 80000000, hi 0; DIVU x/0 -> hi/lo unchanged.
REQ-037 MULT with flush=1 on start cycle -> busy stays 0, hi/lo unchanged; MULT accepted then flush in cycle 2 -> completes normally.
REQ-038 MTLO A=1234 while busy -> ignored; reset asserted mid-DIV -> busy 0, hi=lo=0 next cycle, no later write.
REQ-039 Parameter sweep WIDTH=16, MUL_CYCLES=1, DIV_CYCLES=3 -> LUI B=00AB gives AB00; MULT busy exactly 1 cycle; DIV busy exactly 3 cycles.
